// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial WIDTH-bit adder with a start/done handshake. One sum bit is
// produced per clock. Computes a + b + cin and presents the sum, the unsigned
// carry-out and the two's-complement overflow flag. The result outputs hold
// their value until the next operation completes. Intended to feed a
// downstream enable register directly: done -> en, sum -> d.
//
// Parameters
//   WIDTH     operand/sum width in bits (>= 2)
//
// Ports
//   clk       in   1      clock, rising edge
//   reset     in   1      asynchronous, active-high; clears all state/outputs
//   start     in   1      operation request; only sampled while idle
//   a         in   WIDTH  operand A, captured when start is accepted
//   b         in   WIDTH  operand B, captured when start is accepted
//   cin       in   1      carry-in, captured when start is accepted
//   busy      out  1      high while bits are being shifted through
//   done      out  1      single-cycle completion pulse
//   sum       out  WIDTH  registered result
//   cout      out  1      carry out of the MSB
//   overflow  out  1      carry into MSB xor carry out of MSB
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] psum_q, psum_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic sum_bit;
   logic carry_nxt;
   logic c_msb_in;
   logic last_step;

   // Single full-adder slice working on the LSBs of the operand shifters.
   always_comb begin
      sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
      // On the final step carry_q is exactly the carry into the MSB.
      c_msb_in  = carry_q;
      last_step = (cnt_q == LastCnt);
   end

   // Next-state and datapath.
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      psum_d  = psum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               psum_d  = '0;
               cnt_d   = '0;
               state_d = StShift;
            end
         end

         StShift: begin
            // New sum bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
            psum_d  = WIDTH'({sum_bit, psum_q} >> 1);
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = carry_nxt;
            cnt_d   = cnt_q + CntW'(1);
            if (last_step) begin
               sum_d   = psum_d;
               cout_d  = carry_nxt;
               ovf_d   = c_msb_in ^ carry_nxt;
               state_d = StDone;
            end
         end

         StDone: begin
            // start is deliberately not looked at here; it is not queued.
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         psum_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         psum_q  <= psum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Handshake outputs decode from state only, so they can never overlap.
   always_comb begin
      busy     = (state_q == StShift);
      done     = (state_q == StDone);
      sum      = sum_q;
      cout     = cout_q;
      overflow = ovf_q;
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Self-checking bench for serial_adder_ctrl. Expected results come from an
// arithmetic reference (integer add plus sign-rule overflow). A small model of
// the downstream enable register (en = done, d = sum) counts captures.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;

   int n_checks = 0;
   int n_fails  = 0;

   // Downstream register model.
   logic [W-1:0] dn_q   = '0;
   int           dn_cnt = 0;

   int done_times[$];

   always #5 clk = ~clk;

   serial_adder_ctrl #(
      .WIDTH(W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .busy    (busy),
      .done    (done),
      .sum     (sum),
      .cout    (cout),
      .overflow(overflow)
   );

   always @(posedge clk) begin
      if (done) begin
         dn_q   <= sum;
         dn_cnt <= dn_cnt + 1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Returns {overflow, cout, sum}.
   function automatic logic [W+1:0] model(input int ua, input int ub, input int uc);
      int full;
      int s;
      int co;
      int ov;
      full = ua + ub + uc;
      s    = full % (1 << W);
      co   = full >> W;
      ov   = (((ua >> (W - 1)) & 1) == ((ub >> (W - 1)) & 1)) &&
             (((s >> (W - 1)) & 1) != ((ua >> (W - 1)) & 1)) ? 1 : 0;
      return {ov[0], co[0], s[W-1:0]};
   endfunction

   // Issues one operation from IDLE (called at a negedge) and checks it.
   // poke: re-pulse start with a=1,b=1 during SHIFT. start_in_done: assert
   // start during the DONE cycle. Returns at a negedge with the DUT idle.
   task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         input bit poke, input bit start_in_done);
      logic [W+1:0] exp;
      int           lat;
      bit           got;
      int           cnt0;
      exp   = model(int'(oa), int'(ob), int'(oc));
      cnt0  = dn_cnt;
      a     = oa;
      b     = ob;
      cin   = oc;
      start = 1'b1;
      @(posedge clk);
      #1;
      // Inputs change after capture; they must not affect the result.
      start = poke;
      a     = poke ? W'(1) : W'($urandom);
      b     = poke ? W'(1) : W'($urandom);
      cin   = poke ? 1'b0 : 1'($urandom);
      @(negedge clk);
      check_val("busy_at_capture", {31'b0, busy}, 1);
      lat = 0;
      got = 0;
      while (!got && lat < W + 4) begin
         @(posedge clk);
         lat++;
         #1 start = 1'b0;
         @(negedge clk);
         if (done) got = 1;
         else check_val("busy_in_shift", {31'b0, busy}, 1);
      end
      check_val("done_seen", {31'b0, got}, 1);
      if (!got) return;
      check_val("latency", lat, W);
      check_val("busy_in_done", {31'b0, busy}, 0);
      check_val("sum", {28'b0, sum}, {28'b0, exp[W-1:0]});
      check_val("cout", {31'b0, cout}, {31'b0, exp[W]});
      check_val("overflow", {31'b0, overflow}, {31'b0, exp[W+1]});
      if (start_in_done) begin
         start = 1'b1;
         a     = W'(1);
         b     = W'(1);
         cin   = 1'b0;
      end
      @(negedge clk);
      start = 1'b0;
      check_val("done_single", {31'b0, done}, 0);
      check_val("idle_after_done", {31'b0, busy}, 0);
      check_val("dn_captures", dn_cnt, cnt0 + 1);
      check_val("dn_value", {28'b0, dn_q}, {28'b0, exp[W-1:0]});
      check_val("sum_hold", {28'b0, sum}, {28'b0, exp[W-1:0]});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int prev_done;
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_busy", {31'b0, busy}, 0);
      check_val("rst_done", {31'b0, done}, 0);
      check_val("rst_sum", {28'b0, sum}, 0);
      check_val("rst_cout", {31'b0, cout}, 0);
      check_val("rst_ovf", {31'b0, overflow}, 0);
      reset = 1'b0;
      @(negedge clk);

      // 3 + 5: positive + positive wraps negative.
      run_op(4'h3, 4'h5, 1'b0, 0, 0);

      // Reset two cycles into SHIFT abandons the add.
      a     = 4'h9;
      b     = 4'h3;
      cin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("mid_rst_busy", {31'b0, busy}, 0);
      check_val("mid_rst_done", {31'b0, done}, 0);
      check_val("mid_rst_sum", {28'b0, sum}, 0);
      check_val("mid_rst_cout", {31'b0, cout}, 0);
      check_val("mid_rst_ovf", {31'b0, overflow}, 0);
      @(negedge clk);
      reset  = 1'b0;
      pulses = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check_val("mid_rst_no_done", pulses, 0);
      check_val("mid_rst_idle", {31'b0, busy}, 0);

      // Carry and overflow corners.
      run_op(4'hF, 4'h1, 1'b0, 0, 0);
      run_op(4'h7, 4'h7, 1'b1, 0, 0);
      run_op(4'hF, 4'hF, 1'b1, 0, 0);

      // start during SHIFT and during DONE is ignored; next start is accepted.
      run_op(4'h6, 4'h5, 1'b0, 1, 1);
      run_op(4'h2, 4'h3, 1'b1, 0, 0);

      // start held high: one op every W+2 cycles.
      a         = 4'h2;
      b         = 4'h2;
      cin       = 1'b0;
      start     = 1'b1;
      prev_done = 0;
      for (int i = 0; i < 4 * (W + 2) + 2; i++) begin
         @(negedge clk);
         if (done) begin
            done_times.push_back(i);
            check_val("b2b_sum", {28'b0, sum}, 4);
            check_val("b2b_single", prev_done, 0);
         end
         prev_done = int'(done);
      end
      start = 1'b0;
      check_val("b2b_count", done_times.size(), 4);
      if (done_times.size() > 0) check_val("b2b_first", done_times[0], W);
      for (int i = 1; i < done_times.size(); i++) begin
         check_val("b2b_spacing", done_times[i] - done_times[i-1], W + 2);
      end
      repeat (W + 4) @(negedge clk);

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom), bit'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
